// File: rtl/elevator_pkg.sv
// elevator_pkg: shared floor constants, floor type and dispatcher state encoding
package elevator_pkg;
  localparam int NUM_FLOORS = 7;
  localparam int FLOOR_W = 3;
  typedef logic [FLOOR_W-1:0] floor_t;
  localparam floor_t INVALID_FLOOR = 3'b111;
  typedef enum logic [1:0] {IDLE, ISSUE, HOLDOFF} disp_state_t;
endpackage

// File: rtl/hall_rr_arbiter.sv
// hall_rr_arbiter: combinational round-robin pick; request=pending floors, rr_ptr=search start, grant_valid/grant_floor=winner
module hall_rr_arbiter import elevator_pkg::*; #(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS
) (
  input  logic [NUM_FLOORS-1:0] request,
  input  floor_t                rr_ptr,
  output logic                  grant_valid,
  output floor_t                grant_floor
);
  floor_t idx;
  always_comb begin
    grant_valid = 1'b0;
    grant_floor = '0;
    idx = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      idx = floor_t'((int'(rr_ptr) + i) % NUM_FLOORS);
      if (!grant_valid && request[idx]) begin
        grant_valid = 1'b1;
        grant_floor = idx;
      end
    end
  end
endmodule

// File: rtl/hall_call_dispatcher.sv
// hall_call_dispatcher: latches hall calls, issues them to the car round-robin, clears them on dwell; clk/reset, hall_buttons, current_floor_in in; hall_r_nwr, hall_request_floor, hall_lamps, busy out
module hall_call_dispatcher import elevator_pkg::*; #(
  parameter int NUM_FLOORS     = elevator_pkg::NUM_FLOORS,
  parameter int DWELL_CYCLES   = 2,
  parameter int HOLDOFF_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] hall_buttons,
  input  floor_t                current_floor_in,
  output logic                  hall_r_nwr,
  output floor_t                hall_request_floor,
  output logic [NUM_FLOORS-1:0] hall_lamps,
  output logic                  busy
);
  localparam int DW = $clog2(DWELL_CYCLES + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1) + 1;
  disp_state_t state;
  floor_t rr_ptr, cur_q, grant_floor;
  logic [HW-1:0] hcnt;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [NUM_FLOORS-1:0] unsent, btn_q, press, clr, iss_clr, lamps_n, unsent_n;
  logic armed, grant_valid;
  hall_rr_arbiter #(.NUM_FLOORS(NUM_FLOORS)) u_arb (
    .request(unsent),
    .rr_ptr(rr_ptr),
    .grant_valid(grant_valid),
    .grant_floor(grant_floor)
  );
  // armed stays low for the first edge after reset so levels held through reset only load the history
  always_comb begin
    dcnt_n = (current_floor_in == INVALID_FLOOR) ? '0 :
             (current_floor_in != cur_q || dcnt == '0) ? DW'(1) :
             (dcnt == DW'(DWELL_CYCLES)) ? dcnt : dcnt + 1'b1;
    clr = '0;
    if (dcnt_n == DW'(DWELL_CYCLES) && int'(current_floor_in) < NUM_FLOORS) clr[current_floor_in] = 1'b1;
    press = armed ? (hall_buttons & ~btn_q) & (~hall_lamps | clr) : '0;
    iss_clr = '0;
    if (state == ISSUE) iss_clr[hall_request_floor] = 1'b1;
    lamps_n = (hall_lamps & ~clr) | press;
    unsent_n = (unsent & ~clr & ~iss_clr) | press;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      hcnt <= '0;
      unsent <= '0;
      btn_q <= '0;
      armed <= 1'b0;
      cur_q <= INVALID_FLOOR;
      dcnt <= '0;
      hall_r_nwr <= 1'b1;
      hall_request_floor <= '0;
      hall_lamps <= '0;
      busy <= 1'b0;
    end else begin
      btn_q <= hall_buttons;
      armed <= 1'b1;
      cur_q <= current_floor_in;
      dcnt <= dcnt_n;
      unsent <= unsent_n;
      hall_lamps <= lamps_n;
      busy <= |lamps_n;
      case (state)
        IDLE: if (grant_valid) begin
          state <= ISSUE;
          hall_r_nwr <= 1'b0;
          hall_request_floor <= grant_floor;
        end
        ISSUE: begin
          hall_r_nwr <= 1'b1;
          rr_ptr <= (hall_request_floor == floor_t'(NUM_FLOORS - 1)) ? '0 : hall_request_floor + 1'b1;
          hcnt <= HW'(1);
          state <= (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
        end
        HOLDOFF: if (hcnt >= HW'(HOLDOFF_CYCLES)) state <= IDLE; else hcnt <= hcnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
